pipeline_trace_buffer: RTL and testbench

Synthesizable trace buffer that snoops the write-back stage of the five-stage pipelined datapath. It records one entry per qualifying cycle into a circular buffer of parametrised depth, and freezes capture a programmable number of entries after a PC-match or forced trigger. After capture, the stored history is read back oldest-first through a request/valid port. It sits beside `datapathModule` and replaces waveform-only inspection of `PC`, `dinstOut` and write-back signals.

---
 rtl/pipeline_trace_pkg.sv | 42 ++++
 rtl/pipeline_trace_buffer_ram.sv | 39 +++
 rtl/pipeline_trace_buffer.sv | 162 ++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_trace_pkg
// Purpose  : Shared state encoding and packed-entry layout for the trace buffer
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    // Entry layout, MSB first: {wwreg, wdest, pc, inst, wdata}
    function automatic int entry_w(input int data_w, input int reg_w);
        return 1 + reg_w + 3 * data_w;
    endfunction

    function automatic int off_wdata();
        return 0;
    endfunction

    function automatic int off_inst(input int data_w);
        return data_w;
    endfunction

    function automatic int off_pc(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int off_wdest(input int data_w);
        return 3 * data_w;
    endfunction

    function automatic int off_wwreg(input int data_w, input int reg_w);
        return 3 * data_w + reg_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_trace_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : trace_ram
// Purpose  : Simple dual-port RAM, synchronous write, registered read (1 cycle)
// Revision : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 102,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_trace_buffer
// Purpose  : Write-back stage trace buffer with PC/forced trigger and readout.
//            Define TRACE_WB_FILTER_EN to record only register-writing cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_trace_buffer
    import pipeline_trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    localparam int ENTRY_W  = entry_w(DATA_W, REG_W),
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               trig_en,
    input  logic [DATA_W-1:0]  trig_pc,
    input  logic               force_trig,
    input  logic [DATA_W-1:0]  pc,
    input  logic [DATA_W-1:0]  inst,
    input  logic               wwreg,
    input  logic [REG_W-1:0]   wdest,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               rd_req,
    input  logic [AW-1:0]      rd_idx,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_entry,
    output logic [1:0]         state,
    output logic               triggered,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    localparam int c_off_wdata = off_wdata();
    localparam int c_off_inst  = off_inst(DATA_W);
    localparam int c_off_pc    = off_pc(DATA_W);
    localparam int c_off_wdest = off_wdest(DATA_W);
    localparam int c_off_wwreg = off_wwreg(DATA_W, REG_W);

    trace_state_t     r_state;
    logic [AW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_post;
    logic             r_triggered;
    logic             r_overflow;
    logic             r_rd_valid;

    logic             w_capturing;
    logic             w_qualify;
    logic             w_store;
    logic             w_trigger;
    logic             w_rd_ok;
    logic             w_rd_fire;
    logic [AW-1:0]    w_rd_addr;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_ram_q;

    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);

`ifdef TRACE_WB_FILTER_EN
    assign w_qualify = w_capturing & wwreg;
`else
    assign w_qualify = w_capturing;
`endif

    // A re-arm discards the sample of its own cycle
    assign w_store   = w_qualify & ~arm;
    assign w_trigger = force_trig | (trig_en & (pc == trig_pc));

    always_comb begin
        w_wr_entry = '0;
        w_wr_entry[c_off_wdata +: DATA_W] = wdata;
        w_wr_entry[c_off_inst  +: DATA_W] = inst;
        w_wr_entry[c_off_pc    +: DATA_W] = pc;
        w_wr_entry[c_off_wdest +: REG_W]  = wdest;
        w_wr_entry[c_off_wwreg]           = wwreg;
    end

    // Once wrapped, the oldest surviving entry sits at the write pointer
    assign w_rd_addr = (r_overflow ? r_wptr : '0) + rd_idx;
    assign w_rd_ok   = (r_state == ST_DONE) && (CW'(rd_idx) < r_count);
    assign w_rd_fire = rd_req & w_rd_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wptr      <= '0;
            r_count     <= '0;
            r_post      <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (arm) begin
                r_state     <= ST_ARMED;
                r_wptr      <= '0;
                r_count     <= '0;
                r_post      <= '0;
                r_triggered <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_store) begin
                    r_wptr <= r_wptr + 1'b1;
                    if (r_count != CW'(DEPTH)) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (r_wptr == AW'(DEPTH - 1)) begin
                        r_overflow <= 1'b1;
                    end
                end
                case (r_state)
                    ST_ARMED: begin
                        if (w_trigger) begin
                            r_triggered <= 1'b1;
                            r_post      <= AW'(POST_TRIG);
                            r_state     <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (w_store) begin
                            r_post <= r_post - 1'b1;
                            if (r_post == AW'(1)) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_store),
        .wr_addr (r_wptr),
        .wr_data (w_wr_entry),
        .rd_en   (w_rd_fire),
        .rd_addr (w_rd_addr),
        .rd_data (w_ram_q)
    );

    assign rd_valid  = r_rd_valid;
    assign rd_entry  = r_rd_valid ? w_ram_q : '0;
    assign state     = r_state;
    assign triggered = r_triggered;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_trace_buffer
// Purpose  : Directed self-checking bench; instance a uses POST_TRIG=8,
//            instance b uses POST_TRIG=0, both fed the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_trace_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         arm = 1'b0;
    logic         trig_en = 1'b0;
    logic [31:0]  trig_pc = '0;
    logic         force_trig = 1'b0;
    logic [31:0]  pc = '0;
    logic [31:0]  inst = '0;
    logic         wwreg = 1'b0;
    logic [4:0]   wdest = '0;
    logic [31:0]  wdata = '0;
    logic         rd_req = 1'b0;
    logic [3:0]   rd_idx = '0;

    logic         rd_valid_a, rd_valid_b;
    logic [101:0] rd_entry_a, rd_entry_b;
    logic [1:0]   state_a, state_b;
    logic         triggered_a, triggered_b;
    logic [4:0]   count_a, count_b;
    logic         overflow_a, overflow_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        bit va;
        int pca;
        bit vb;
        int pcb;
    } rd_vec_t;

    rd_vec_t short_tbl [6];
    rd_vec_t wrap_tbl  [6];

    pipeline_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(16), .POST_TRIG(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .pc(pc), .inst(inst), .wwreg(wwreg), .wdest(wdest),
        .wdata(wdata), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid_a),
        .rd_entry(rd_entry_a), .state(state_a), .triggered(triggered_a),
        .count(count_a), .overflow(overflow_a)
    );

    pipeline_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(16), .POST_TRIG(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .pc(pc), .inst(inst), .wwreg(wwreg), .wdest(wdest),
        .wdata(wdata), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid_b),
        .rd_entry(rd_entry_b), .state(state_b), .triggered(triggered_b),
        .count(count_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int k, input bit w);
        pc    = 32'(4 * k);
        inst  = 32'hA000_0000 | 32'(k);
        wdata = ~(32'(4 * k));
        wdest = 5'(k);
        wwreg = w;
    endtask

    task automatic feed(input int k0, input int n, input int force_k, input bit alt);
        for (int k = k0; k < k0 + n; k++) begin
            set_sample(k, alt ? (k % 2 == 0) : 1'b1);
            force_trig = (k == force_k);
            tick();
        end
        force_trig = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input bit va, input int pca, input bit vb, input int pcb);
        chk({tag, " valid_a"}, 128'(rd_valid_a), 128'(va));
        if (va) chk({tag, " pc_a"}, 128'(rd_entry_a[95:64]), 128'(32'(pca)));
        else    chk({tag, " entry_a"}, 128'(rd_entry_a), 128'(0));
        chk({tag, " valid_b"}, 128'(rd_valid_b), 128'(vb));
        if (vb) chk({tag, " pc_b"}, 128'(rd_entry_b[95:64]), 128'(32'(pcb)));
        else    chk({tag, " entry_b"}, 128'(rd_entry_b), 128'(0));
    endtask

    // Back-to-back reads, one per cycle, each checked one cycle after issue
    task automatic run_reads(input string tag, input rd_vec_t tbl [6]);
        for (int i = 0; i < 6; i++) begin
            rd_req = 1'b1;
            rd_idx = 4'(tbl[i].idx);
            tick();
            chk_rd($sformatf("%s idx%0d", tag, tbl[i].idx), tbl[i].va, tbl[i].pca, tbl[i].vb, tbl[i].pcb);
        end
        rd_req = 1'b0;
        tick();
        chk({tag, " valid_a drops"}, 128'(rd_valid_a), 128'(0));
        chk({tag, " valid_b drops"}, 128'(rd_valid_b), 128'(0));
    endtask

    task automatic single_read(input string tag, input int idx, input bit va, input int pca, input bit vb, input int pcb);
        rd_req = 1'b1;
        rd_idx = 4'(idx);
        tick();
        rd_req = 1'b0;
        chk_rd(tag, va, pca, vb, pcb);
    endtask

    initial begin
        // Short capture: a holds 13 entries (pc 0..48), b holds 5 (pc 0..16)
        short_tbl[0] = '{idx: 0,  va: 1, pca: 0,  vb: 1, pcb: 0};
        short_tbl[1] = '{idx: 4,  va: 1, pca: 16, vb: 1, pcb: 16};
        short_tbl[2] = '{idx: 5,  va: 1, pca: 20, vb: 0, pcb: 0};
        short_tbl[3] = '{idx: 12, va: 1, pca: 48, vb: 0, pcb: 0};
        short_tbl[4] = '{idx: 13, va: 0, pca: 0,  vb: 0, pcb: 0};
        short_tbl[5] = '{idx: 15, va: 0, pca: 0,  vb: 0, pcb: 0};
        // Wrap: a stored samples 0..40 (oldest k=25), b stored 0..32 (oldest k=17)
        wrap_tbl[0] = '{idx: 0,  va: 1, pca: 'h64, vb: 1, pcb: 'h44};
        wrap_tbl[1] = '{idx: 1,  va: 1, pca: 'h68, vb: 1, pcb: 'h48};
        wrap_tbl[2] = '{idx: 7,  va: 1, pca: 'h80, vb: 1, pcb: 'h60};
        wrap_tbl[3] = '{idx: 8,  va: 1, pca: 'h84, vb: 1, pcb: 'h64};
        wrap_tbl[4] = '{idx: 14, va: 1, pca: 'h9C, vb: 1, pcb: 'h7C};
        wrap_tbl[5] = '{idx: 15, va: 1, pca: 'hA0, vb: 1, pcb: 'h80};

        // Reset values
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset state",    128'(state_a),     128'(0));
        chk("reset count",    128'(count_a),     128'(0));
        chk("reset rd_valid", 128'(rd_valid_a),  128'(0));
        chk("reset overflow", 128'(overflow_a),  128'(0));
        chk("reset trig",     128'(triggered_a), 128'(0));
        chk("reset entry",    128'(rd_entry_a),  128'(0));

        // Short capture with forced trigger on the 5th sample; PC match disabled
        trig_pc = 32'h08;
        trig_en = 1'b0;
        arm_pulse();
        chk("armed state", 128'(state_a), 128'(1));
        feed(0, 12, 4, 1'b0);
        chk("short a post",     128'(state_a), 128'(2));
        chk("short a count12",  128'(count_a), 128'(12));
        chk("short b done",     128'(state_b), 128'(3));
        chk("short b count",    128'(count_b), 128'(5));
        chk("short b trig",     128'(triggered_b), 128'(1));
        feed(12, 1, -1, 1'b0);
        chk("short a done",     128'(state_a), 128'(3));
        chk("short a count",    128'(count_a), 128'(13));
        chk("short a overflow", 128'(overflow_a), 128'(0));
        chk("short a trig",     128'(triggered_a), 128'(1));
        feed(13, 3, -1, 1'b0);
        chk("short a count hold", 128'(count_a), 128'(13));
        run_reads("short", short_tbl);

        // Wrap with PC-match trigger at pc=0x80 (33rd sample)
        arm_pulse();
        trig_pc = 32'h80;
        trig_en = 1'b1;
        feed(0, 32, -1, 1'b0);
        chk("wrap pre state", 128'(state_a), 128'(1));
        chk("wrap pre trig",  128'(triggered_a), 128'(0));
        chk("wrap pre ovf",   128'(overflow_a), 128'(1));
        chk("wrap pre count", 128'(count_a), 128'(16));
        feed(32, 1, -1, 1'b0);
        chk("wrap a post",  128'(state_a), 128'(2));
        chk("wrap a trig",  128'(triggered_a), 128'(1));
        chk("wrap b done",  128'(state_b), 128'(3));
        feed(33, 7, -1, 1'b0);
        chk("wrap a still post", 128'(state_a), 128'(2));
        feed(40, 1, -1, 1'b0);
        chk("wrap a done",  128'(state_a), 128'(3));
        chk("wrap a count", 128'(count_a), 128'(16));
        trig_en = 1'b0;
        run_reads("wrap", wrap_tbl);

        // Write-back filter on b: wwreg alternates 1/0, force on 20th sample (wwreg=0)
        arm_pulse();
        feed(0, 20, 19, 1'b1);
        chk("filter b state", 128'(state_b), 128'(3));
        chk("filter b trig",  128'(triggered_b), 128'(1));
        chk("filter a post",  128'(state_a), 128'(2));
`ifdef TRACE_WB_FILTER_EN
        chk("filter b count", 128'(count_b), 128'(10));
        chk("filter b ovf",   128'(overflow_b), 128'(0));
        for (int i = 0; i < 10; i++) begin
            rd_req = 1'b1;
            rd_idx = 4'(i);
            tick();
            chk($sformatf("filter idx%0d valid", i), 128'(rd_valid_b), 128'(1));
            chk($sformatf("filter idx%0d pc", i), 128'(rd_entry_b[95:64]), 128'(32'(8 * i)));
            chk($sformatf("filter idx%0d wwreg", i), 128'(rd_entry_b[101]), 128'(1));
        end
`else
        chk("filter b count", 128'(count_b), 128'(16));
        chk("filter b ovf",   128'(overflow_b), 128'(1));
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1;
            rd_idx = 4'(i);
            tick();
            chk($sformatf("filter idx%0d valid", i), 128'(rd_valid_b), 128'(1));
            chk($sformatf("filter idx%0d pc", i), 128'(rd_entry_b[95:64]), 128'(32'(4 * (4 + i))));
            chk($sformatf("filter idx%0d wwreg", i), 128'(rd_entry_b[101]), 128'(((4 + i) % 2) == 0));
        end
`endif
        rd_req = 1'b0;

        // arm and force_trig together: arm wins, sample not stored
        set_sample(100, 1'b1);
        arm = 1'b1;
        force_trig = 1'b1;
        tick();
        arm = 1'b0;
        force_trig = 1'b0;
        chk("prio a state", 128'(state_a), 128'(1));
        chk("prio a trig",  128'(triggered_a), 128'(0));
        chk("prio a count", 128'(count_a), 128'(0));
        chk("prio b state", 128'(state_b), 128'(1));
        chk("prio b count", 128'(count_b), 128'(0));
        single_read("armed read", 0, 1'b0, 0, 1'b0, 0);
        chk("armed read stored", 128'(count_a), 128'(1));
        feed(101, 2, 102, 1'b0);
        chk("restart a post",  128'(state_a), 128'(2));
        chk("restart a count", 128'(count_a), 128'(3));
        arm_pulse();
        chk("rearm a state", 128'(state_a), 128'(1));
        chk("rearm a count", 128'(count_a), 128'(0));
        chk("rearm a trig",  128'(triggered_a), 128'(0));

        // Asynchronous reset while in POST
        feed(200, 2, 200, 1'b0);
        chk("pre-reset a post", 128'(state_a), 128'(2));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset state", 128'(state_a), 128'(0));
        chk("async reset count", 128'(count_a), 128'(0));
        chk("async reset trig",  128'(triggered_a), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        single_read("post-reset read", 0, 1'b0, 0, 1'b0, 0);
        chk("post-reset state", 128'(state_a), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
